// File: rtl/activation_unit.sv
// activation_unit: per-lane activation (bypass / ReLU / clipped ReLU / leaky ReLU)
//   with saturation to a narrower signed output. Latency 2 cycles (activation
//   register, then saturated output register); one beat per cycle when unstalled.
// Backpressure: each stage loads only when the stage after it is empty or draining;
//   enable=0 freezes every register and forces in_ready low.
// Ports: clk, rst_n (async, active low), enable, mode/clip_max/leak_shift (captured
//   per accepted beat), in_data/in_valid/in_ready, out_data/out_valid/out_ready.
// Optional macro ACTIVATION_UNIT_STATS_EN adds stats_clr, zero_count, sat_count.
module activation_unit #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int LANES     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic [OUT_WIDTH-1:0]           clip_max,
  input  logic [2:0]                     leak_shift,
  input  logic [LANES*IN_WIDTH-1:0]      in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [LANES*OUT_WIDTH-1:0]     out_data,
  output logic                           out_valid,
  input  logic                           out_ready
`ifdef ACTIVATION_UNIT_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [31:0]                    zero_count,
  output logic [31:0]                    sat_count
`endif
);

  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [IN_WIDTH-1:0] activate(
    input logic signed [IN_WIDTH-1:0] x,
    input logic [1:0]                 m,
    input logic signed [IN_WIDTH-1:0] c,
    input logic [2:0]                 s
  );
    logic neg;
    neg = x[IN_WIDTH-1];
    case (m)
      2'b01:   activate = neg ? '0 : x;
      2'b10:   activate = neg ? '0 : ((x > c) ? c : x);
      2'b11:   activate = neg ? (x >>> s) : x;
      default: activate = x;
    endcase
  endfunction

  // A clip ceiling with the top bit set would read as negative once signed,
  // so it is pulled down to the largest positive output value first.
  logic [OUT_WIDTH-1:0]        clip_eff;
  logic signed [IN_WIDTH-1:0]  clip_ext;
  assign clip_eff = clip_max[OUT_WIDTH-1] ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : clip_max;
  assign clip_ext = IN_WIDTH'(clip_eff);

  logic                          run;
  logic                          s1_valid;
  logic [LANES*IN_WIDTH-1:0]     s1_data;
  logic [LANES*IN_WIDTH-1:0]     act_data;
  logic [LANES*OUT_WIDTH-1:0]    sat_data;
  logic                          out_load;
  logic                          s1_adv;
  logic                          in_xfer;
  logic                          out_xfer;

  // The output register may take a new beat when empty or being drained.
  assign out_load = enable && (!out_valid || out_ready);
  assign s1_adv   = s1_valid && out_load;
  assign in_ready = enable && run && (!s1_valid || s1_adv);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready && enable;

`ifdef ACTIVATION_UNIT_STATS_EN
  logic [LANES-1:0] sat_flag;
  logic [LANES-1:0] out_sat;
  logic [LANES-1:0] zero_flag;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [IN_WIDTH-1:0] v;
    assign act_data[l*IN_WIDTH +: IN_WIDTH] =
      activate(in_data[l*IN_WIDTH +: IN_WIDTH], mode, clip_ext, leak_shift);
    assign v = s1_data[l*IN_WIDTH +: IN_WIDTH];
    assign sat_data[l*OUT_WIDTH +: OUT_WIDTH] =
      (v > SAT_HI) ? SAT_HI[OUT_WIDTH-1:0] :
      (v < SAT_LO) ? SAT_LO[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
`ifdef ACTIVATION_UNIT_STATS_EN
    assign sat_flag[l]  = (v > SAT_HI) || (v < SAT_LO);
    assign zero_flag[l] = (out_data[l*OUT_WIDTH +: OUT_WIDTH] == '0);
`endif
  end

  // in_ready stays low out of reset until the first edge that sees enable=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else if (enable) begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_data  <= act_data;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= sat_data;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ACTIVATION_UNIT_STATS_EN
  function automatic logic [31:0] popcount(input logic [LANES-1:0] f);
    popcount = '0;
    for (int i = 0; i < LANES; i++) begin
      popcount = popcount + 32'(f[i]);
    end
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add = sum[32] ? '1 : sum[31:0];
  endfunction

  // Saturation flags travel with the beat so they describe the lanes on out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat <= '0;
    end else if (s1_adv) begin
      out_sat <= sat_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_count <= '0;
      sat_count  <= '0;
    end else if (stats_clr) begin
      zero_count <= '0;
      sat_count  <= '0;
    end else if (out_xfer) begin
      zero_count <= sat_add(zero_count, popcount(zero_flag));
      sat_count  <= sat_add(sat_count, popcount(out_sat));
    end
  end
`endif

endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit: directed and randomized checks of activation_unit against
//   a lane-by-lane arithmetic model and an in-order expected-beat queue.
// Inputs change 1 time unit after the rising edge; outputs are read 3 after it.
module tb_activation_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  clip_max;
  logic [2:0]  leak_shift;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef ACTIVATION_UNIT_STATS_EN
  logic        stats_clr;
  logic [31:0] zero_count;
  logic [31:0] sat_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  activation_unit dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .clip_max(clip_max),
    .leak_shift(leak_shift), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ACTIVATION_UNIT_STATS_EN
    , .stats_clr(stats_clr), .zero_count(zero_count), .sat_count(sat_count)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int model_lane(int x, int m, int c, int s);
    int y;
    int ceil_c;
    ceil_c = (c > 127) ? 127 : c;
    case (m)
      1:       y = (x < 0) ? 0 : x;
      2:       y = (x < 0) ? 0 : ((x > ceil_c) ? ceil_c : x);
      3:       y = (x < 0) ? (x >>> s) : x;
      default: y = x;
    endcase
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  function automatic logic [31:0] model_beat(logic [1:0] m, logic [7:0] c, logic [2:0] s,
                                             logic [63:0] d);
    logic [31:0]        r;
    logic signed [15:0] xs;
    int                 y;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      xs = d[16*l +: 16];
      y  = model_lane(int'(xs), int'(m), int'(c), int'(s));
      r[8*l +: 8] = 8'(y);
    end
    return r;
  endfunction

  function automatic logic [63:0] pack_in(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [31:0] pack_out(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [15:0] rand_lane();
    if ($urandom_range(0, 1) == 1) return 16'($urandom);
    return 16'($urandom_range(0, 600) - 300);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat until accepted; returns at accept edge + 1.
  task automatic send(input logic [1:0] m, input logic [7:0] c, input logic [2:0] s,
                      input logic [63:0] d, output bit ok);
    mode = m; clip_max = c; leak_shift = s; in_data = d; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #2;
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Sends a beat with out_ready=1 and captures the first output beat. lat counts
  // the cycle the beat was presented plus the cycles until out_valid is seen.
  task automatic send_and_get(input logic [1:0] m, input logic [7:0] c, input logic [2:0] s,
                              input logic [63:0] d, output bit ok, output logic [31:0] got,
                              output int lat);
    bit seen;
    out_ready = 1'b1;
    send(m, c, s, d, ok);
    got  = 'x;
    lat  = -1;
    seen = 1'b0;
    for (int i = 0; i < 10 && ok && !seen; i++) begin
      #2;
      if (out_valid) begin
        seen = 1'b1;
        got  = out_data;
        lat  = i + 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_data = pack_in(1, 2, 3, 4);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    #2;
    rst_n = 1'b1; enable = 1'b0; in_valid = 1'b0;
    sync();
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_while_disabled: got %b want 0", in_ready); end
    enable = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_enable_edge: got %b want 0", in_ready); end
    @(posedge clk);
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_enable_edge: got %b want 1", in_ready); end
    #(-0) ;
    sync();
  endtask

  task automatic test_relu();
    bit ok; logic [31:0] got; int lat;
    send_and_get(2'b01, 8'd0, 3'd0, pack_in(-5, 100, 300, 0), ok, got, lat);
    n_checks++; if (!ok || lat !== 2) begin n_fail++; $display("FAIL relu_latency: got %0d want 2 (accepted=%0d)", lat, ok); end
    n_checks++; if (got !== pack_out(0, 100, 127, 0)) begin n_fail++; $display("FAIL relu_data: got %h want %h", got, pack_out(0, 100, 127, 0)); end
  endtask

  task automatic test_clip();
    bit ok; logic [31:0] got; int lat;
    send_and_get(2'b10, 8'd6, 3'd0, pack_in(10, 3, -2, 6), ok, got, lat);
    n_checks++; if (got !== pack_out(6, 3, 0, 6)) begin n_fail++; $display("FAIL clip6_data: got %h want %h", got, pack_out(6, 3, 0, 6)); end
    send_and_get(2'b10, 8'd200, 3'd0, pack_in(150, -1, 50, 127), ok, got, lat);
    n_checks++; if (got !== pack_out(127, 0, 50, 127)) begin n_fail++; $display("FAIL clip200_data: got %h want %h", got, pack_out(127, 0, 50, 127)); end
  endtask

  task automatic test_leaky();
    bit ok; logic [31:0] got; int lat;
    send_and_get(2'b11, 8'd0, 3'd2, pack_in(-8, -1, -1000, 40), ok, got, lat);
    n_checks++; if (got !== pack_out(-2, -1, -128, 40)) begin n_fail++; $display("FAIL leaky_data: got %h want %h", got, pack_out(-2, -1, -128, 40)); end
    send_and_get(2'b00, 8'd0, 3'd0, pack_in(-129, 200, -128, 127), ok, got, lat);
    n_checks++; if (got !== pack_out(-128, 127, -128, 127)) begin n_fail++; $display("FAIL bypass_sat_data: got %h want %h", got, pack_out(-128, 127, -128, 127)); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcvd = 0;
    bit stall_seen = 0;
    int stall_at = -1;
    mode = 2'b00; clip_max = 8'd0; leak_shift = 3'd0;
    for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 5);
      in_data   = pack_in(sent + 1, sent + 1, sent + 1, sent + 1);
      #2;
      if (in_valid && !in_ready && !stall_seen) begin
        stall_seen = 1'b1;
        stall_at   = sent;
      end
      if (out_valid && !out_ready) begin
        n_checks++; if (out_data !== pack_out(1, 1, 1, 1)) begin n_fail++; $display("FAIL bp_hold: got %h want %h", out_data, pack_out(1, 1, 1, 1)); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_data !== pack_out(rcvd + 1, rcvd + 1, rcvd + 1, rcvd + 1)) begin
          n_fail++; $display("FAIL bp_order: got %h want %h", out_data, pack_out(rcvd + 1, rcvd + 1, rcvd + 1, rcvd + 1));
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (stall_at !== 2) begin n_fail++; $display("FAIL bp_stall_point: got %0d want 2", stall_at); end
    n_checks++; if (rcvd !== 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", rcvd); end
  endtask

  task automatic test_reset_midstream();
    int leaked = 0;
    out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1;
    in_data = pack_in(9, 9, 9, 9);
    sync();
    in_data = pack_in(7, 7, 7, 7);
    sync();
    in_valid = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_in_flight: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", out_data); end
    sync();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (out_valid) leaked++;
      sync();
    end
    n_checks++; if (leaked !== 0) begin n_fail++; $display("FAIL mid_rst_leak: got %0d beats want 0", leaked); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_b[8];
    out_ready = 1'b1; enable = 1'b1; mode = 2'b01; clip_max = 8'd0; leak_shift = 3'd0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc < 8);
      in_data  = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      if (cyc < 8) exp_b[cyc] = model_beat(mode, clip_max, leak_shift, in_data);
      #2;
      if (cyc < 8) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cyc%0d: got %b want 1", cyc, in_ready); end
      end
      if (cyc >= 2 && cyc < 10) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_b[cyc-2]) begin
          n_fail++; $display("FAIL b2b_out cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid, out_data, exp_b[cyc-2]);
        end
      end
      sync();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic        p_vld = 1'b0;
    logic        p_take = 1'b0;
    logic [31:0] p_dat = '0;
    logic [31:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      enable     = ($urandom_range(0, 9) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      in_valid   = ($urandom_range(0, 9) < 7);
      mode       = 2'($urandom_range(0, 3));
      clip_max   = 8'($urandom_range(0, 255));
      leak_shift = 3'($urandom_range(0, 7));
      in_data    = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      #2;
      if (!enable) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_disabled: got %b want 0", in_ready); end
      end
      if (p_vld && !p_take) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== p_dat) begin
          n_fail++; $display("FAIL rnd_hold: got v=%b %h want v=1 %h", out_valid, out_data, p_dat);
        end
      end
      if (in_valid && in_ready && enable) exp_q.push_back(model_beat(mode, clip_max, leak_shift, in_data));
      if (out_valid && out_ready && enable) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_unexpected: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin n_fail++; $display("FAIL rnd_data: got %h want %h", out_data, e); end
        end
      end
      p_vld  = out_valid;
      p_dat  = out_data;
      p_take = out_ready && enable;
      sync();
    end
    in_valid = 1'b0; out_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      #2;
      if (out_valid) begin
        e = exp_q.pop_front();
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", out_data, e); end
      end
      sync();
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_lost: got %0d pending want 0", exp_q.size()); end
  endtask

`ifdef ACTIVATION_UNIT_STATS_EN
  task automatic test_stats();
    bit ok; logic [31:0] got; int lat;
    stats_clr = 1'b1;
    sync();
    stats_clr = 1'b0;
    send_and_get(2'b01, 8'd0, 3'd0, pack_in(-5, 100, 300, 0), ok, got, lat);
    #2;
    n_checks++; if (zero_count !== 32'd2) begin n_fail++; $display("FAIL stats_zero: got %0d want 2", zero_count); end
    n_checks++; if (sat_count !== 32'd1) begin n_fail++; $display("FAIL stats_sat: got %0d want 1", sat_count); end
    sync();
    out_ready = 1'b1;
    send(2'b01, 8'd0, 3'd0, pack_in(0, 0, 500, 0), ok);
    for (int i = 0; i < 5 && !out_valid; i++) sync();
    stats_clr = 1'b1;
    sync();
    stats_clr = 1'b0;
    #2;
    n_checks++; if (zero_count !== 32'd0) begin n_fail++; $display("FAIL stats_clr_zero: got %0d want 0", zero_count); end
    n_checks++; if (sat_count !== 32'd0) begin n_fail++; $display("FAIL stats_clr_sat: got %0d want 0", sat_count); end
    sync();
  endtask
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; clip_max = 8'd0; leak_shift = 3'd0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef ACTIVATION_UNIT_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_relu();
    test_clip();
    test_leaky();
    test_backpressure();
    test_reset_midstream();
    sync();
    test_back_to_back();
    test_random();
`ifdef ACTIVATION_UNIT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
